riscv_iter_alu: RTL and testbench

Area-reduced RV32I ALU for the multicycle core. It sits directly upstream of the ALU output register and drives its ALUResult input.
- Logic and arithmetic ops complete in one cycle.
- SLL/SRL/SRA are computed iteratively, SHIFT_STEP bits per cycle, which removes the 32-bit barrel shifter.
- A start/busy/done handshake lets the control FSM stall in its execute state until done.

---
 rtl/riscv_alu_pkg.sv | 44 ++++
 rtl/riscv_shift_step.sv | 24 ++
 rtl/riscv_iter_alu.sv | 93 +++++++++
 tb/tb_riscv_iter_alu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared opcode encodings, FSM state type and single-cycle ALU function
// for the iterative-shift RV32I ALU.
package riscv_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic [31:0] alu_comb(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : '0;
      ALU_SLTU: r = (a < b) ? 32'd1 : '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_shift_step.sv
// One iteration of the shifter: shifts the accumulator by a small amount k
// (at most SHIFT_STEP) with logical or arithmetic fill.
module riscv_shift_step
  import riscv_alu_pkg::*;
(
  input  logic [31:0] i_acc,
  input  logic        i_left,
  input  logic        i_arith,
  input  logic [4:0]  i_k,
  output logic [31:0] o_shifted
);

  // Branches kept separate so the arithmetic shift stays in a signed context.
  always_comb begin
    o_shifted = i_acc;
    if (i_left)
      o_shifted = i_acc << i_k;
    else if (i_arith)
      o_shifted = $signed(i_acc) >>> i_k;
    else
      o_shifted = i_acc >> i_k;
  end

endmodule

// File: rtl/riscv_iter_alu.sv
// RV32I ALU with single-cycle logic/arithmetic and iterative shifts,
// exposing a start/busy/done handshake to the multicycle control FSM.
module riscv_iter_alu
  import riscv_alu_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

  alu_state_t  r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [3:0]  r_op;

  logic [4:0]  w_k;
  logic [31:0] w_shifted;

  assign w_k  = (r_cnt < STEP5) ? r_cnt : STEP5;
  assign Zero = (ALUResult == '0);

  riscv_shift_step u_step (
    .i_acc     (r_acc),
    .i_left    (r_op == ALU_SLL),
    .i_arith   (r_op == ALU_SRA),
    .i_k       (w_k),
    .o_shifted (w_shifted)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_op      <= ALU_ADD;
      ALUResult <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            r_op <= ALUControl;
            if (!is_shift(ALUControl)) begin
              ALUResult <= alu_comb(ALUControl, SrcA, SrcB);
              r_state   <= ST_DONE;
              done      <= 1'b1;
            end else if (SrcB[4:0] == '0) begin
              ALUResult <= SrcA;
              r_state   <= ST_DONE;
              done      <= 1'b1;
            end else begin
              r_acc   <= SrcA;
              r_cnt   <= SrcB[4:0];
              r_state <= ST_SHIFT;
              busy    <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_acc <= w_shifted;
          r_cnt <= r_cnt - w_k;
          if (r_cnt == w_k) begin
            ALUResult <= w_shifted;
            r_state   <= ST_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_iter_alu.sv
// Directed bench: STEP=1 and STEP=4 instances share stimulus; table-driven
// vectors plus handshake, back-to-back and mid-shift reset sequences.
module tb_riscv_iter_alu;
  import riscv_alu_pkg::*;

  logic        clk, rst, start;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA, SrcB;
  logic [31:0] res1, res4;
  logic        zero1, zero4, busy1, busy4, done1, done4;

  int nchecks = 0;
  int nerr    = 0;

  riscv_iter_alu #(.SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .ALUResult(res1), .Zero(zero1),
    .busy(busy1), .done(done1));

  riscv_iter_alu #(.SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .ALUResult(res4), .Zero(zero4),
    .busy(busy4), .done(done4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and tracks both instances until each has pulsed done.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat1, input int lat4,
                        input logic [31:0] prev, input bit poke);
    int l1, l4, b1, b4;
    logic [31:0] r1, r4;
    l1 = 0; l4 = 0; b1 = 0; b4 = 0; r1 = 'x; r4 = 'x;
    ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
    tick();
    start = 1'b0; SrcA = ~a; SrcB = ~b; ALUControl = ALU_SUB;
    for (int c = 1; c <= 64; c++) begin
      if (busy1) b1++;
      if (busy4) b4++;
      if (done1 && l1 == 0) begin l1 = c; r1 = res1; end
      if (done4 && l4 == 0) begin l4 = c; r4 = res4; end
      if (c == 2 && !done1 && l1 == 0) chk({nm, "_hold1"}, res1, prev);
      if (c == 2 && !done4 && l4 == 0) chk({nm, "_hold4"}, res4, prev);
      if (l1 != 0 && l4 != 0) break;
      if (poke && c >= 3 && c <= 5) begin
        start = 1'b1; ALUControl = ALU_ADD; SrcA = 32'd1; SrcB = 32'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({nm, "_lat1"}, 32'(l1), 32'(lat1));
    chk({nm, "_lat4"}, 32'(l4), 32'(lat4));
    chk({nm, "_res1"}, r1, exp);
    chk({nm, "_res4"}, r4, exp);
    chk({nm, "_busy1"}, 32'(b1), 32'(lat1 - 1));
    chk({nm, "_busy4"}, 32'(b4), 32'(lat4 - 1));
    tick();
    chk({nm, "_zero1"}, {31'd0, zero1}, {31'd0, exp == 32'd0});
    chk({nm, "_zero4"}, {31'd0, zero4}, {31'd0, exp == 32'd0});
    chk({nm, "_pulse"}, {30'd0, done1, done4}, 32'd0);
    chk({nm, "_held1"}, res1, exp);
  endtask

  initial begin
    int ndone;
    vecs[0]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1,  1};
    vecs[1]  = '{ALU_SUB,  32'h5,        32'h7,        32'hFFFFFFFE, 1,  1};
    vecs[2]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1,  1};
    vecs[3]  = '{ALU_OR,   32'h0F0,      32'h00F,      32'h0FF,      1,  1};
    vecs[4]  = '{ALU_XOR,  32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1,  1};
    vecs[5]  = '{ALU_SLT,  32'h80000000, 32'h0,        32'h1,        1,  1};
    vecs[6]  = '{ALU_SLT,  32'h1,        32'h80000000, 32'h0,        1,  1};
    vecs[7]  = '{ALU_SLTU, 32'h1,        32'h80000000, 32'h1,        1,  1};
    vecs[8]  = '{ALU_SLTU, 32'h80000000, 32'h0,        32'h0,        1,  1};
    vecs[9]  = '{4'hF,     32'h123,      32'h1,        32'h0,        1,  1};
    vecs[10] = '{4'hA,     32'h5,        32'h5,        32'h0,        1,  1};
    vecs[11] = '{ALU_SLL,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1,  1};
    vecs[12] = '{ALU_SLL,  32'h1,        32'd31,       32'h80000000, 32, 9};
    vecs[13] = '{ALU_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 32, 9};
    vecs[14] = '{ALU_SRL,  32'hF0000000, 32'd7,        32'h01E00000, 8,  3};
    vecs[15] = '{ALU_SRA,  32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 5,  2};
    vecs[16] = '{ALU_SLL,  32'h12345678, 32'd8,        32'h34567800, 9,  3};
    vecs[17] = '{ALU_SRL,  32'h80000000, 32'h25,       32'h04000000, 6,  3};
    vecs[18] = '{ALU_SRA,  32'hF0000000, 32'd1,        32'hF8000000, 2,  2};

    rst = 1'b0; start = 1'b0; ALUControl = ALU_ADD; SrcA = '0; SrcB = '0;
    #1;
    chk("rst_res1", res1, 32'h0);
    chk("rst_res4", res4, 32'h0);
    chk("rst_flags", {28'd0, zero1, done1, busy1, zero4}, 32'h8 | 32'h1);
    chk("rst_flags4", {30'd0, done4, busy4}, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    chk("idle_res1", res1, 32'h0);
    chk("idle_flags", {28'd0, zero1, done1, busy1, done4}, 32'h8);

    for (int i = 0; i < 19; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat1, vecs[i].lat4, (i == 0) ? 32'h0 : vecs[i-1].exp, 1'b0);

    // start re-asserted during SHIFT must be ignored
    run_op("ign", ALU_SRL, 32'h80000000, 32'd31, 32'h00000001, 32, 9, 32'hF8000000, 1'b1);

    // back-to-back issue from the DONE cycle
    ALUControl = ALU_ADD; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1;
    tick();
    chk("b2b_first", {31'd0, done1}, 32'd1);
    chk("b2b_first_res", res1, 32'd2);
    ALUControl = ALU_OR; SrcA = 32'h0F0; SrcB = 32'h00F;
    tick();
    chk("b2b_second", {30'd0, done1, done4}, 32'd3);
    chk("b2b_second_res1", res1, 32'h0FF);
    chk("b2b_second_res4", res4, 32'h0FF);
    start = 1'b0;
    tick();
    chk("b2b_after", {30'd0, done1, done4}, 32'd0);
    chk("b2b_hold", res1, 32'h0FF);

    // reset in the middle of a shift aborts it
    ALUControl = ALU_SRA; SrcA = 32'h80000000; SrcB = 32'd31; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_busy_pre", {30'd0, busy1, busy4}, 32'd3);
    rst = 1'b0;
    #1;
    chk("mid_rst_res1", res1, 32'h0);
    chk("mid_rst_res4", res4, 32'h0);
    chk("mid_rst_flags", {28'd0, busy1, busy4, done1, done4}, 32'h0);
    chk("mid_rst_zero", {30'd0, zero1, zero4}, 32'd3);
    tick(); tick();
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done1 || done4 || busy1 || busy4) ndone++;
    end
    chk("mid_no_done", 32'(ndone), 32'd0);
    run_op("post_rst", ALU_ADD, 32'd3, 32'd4, 32'd7, 1, 1, 32'h0, 1'b0);
    run_op("post_rst_sh", ALU_SLL, 32'h3, 32'd2, 32'hC, 3, 1 + 1 + 0, 32'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
